// File: rtl/ifu_pkg.sv
// ifu_pkg: state encoding and architectural constants shared by the fetch unit
package ifu_pkg;
   localparam int XLEN = 64;
   localparam logic [XLEN-1:0] RESET_PC = 64'h8000_0000;
   typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_HALT} state_t;
endpackage

// File: rtl/ifu.sv
// ifu: owns the PC, fetches one word at a time from imem and hands it to decode
module ifu
   import ifu_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = ifu_pkg::RESET_PC
) (
   input  logic            clock,
   input  logic            reset,
   output logic            io_imem_req_valid,
   input  logic            io_imem_req_ready,
   output logic [XLEN-1:0] io_imem_req_addr,
   input  logic            io_imem_resp_valid,
   input  logic [31:0]     io_imem_resp_data,
   input  logic            io_redirect_valid,
   input  logic [XLEN-1:0] io_redirect_pc,
   input  logic            io_halt,
   output logic            io_out_valid,
   input  logic            io_out_ready,
   output logic [31:0]     io_out_inst,
   output logic [XLEN-1:0] io_out_pc
);
   state_t          state;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] pc_q;
   logic [31:0]     inst_q;
   logic            kill;
   logic [XLEN-1:0] redirect_pc;
   assign redirect_pc       = {io_redirect_pc[XLEN-1:2], 2'b00};
   assign io_imem_req_valid = ~reset & (state == S_REQ);
   assign io_imem_req_addr  = pc;
   // a redirect drops the held instruction, so it must never be offered that cycle
   assign io_out_valid      = ~reset & (state == S_HOLD) & ~io_redirect_valid;
   assign io_out_inst       = inst_q;
   assign io_out_pc         = pc_q;
   always_ff @(posedge clock) begin
      if (reset) begin
         state  <= S_REQ;
         pc     <= RESET_PC;
         kill   <= 1'b0;
         inst_q <= '0;
         pc_q   <= '0;
      end else begin
         case (state)
            S_REQ: begin
               if (io_redirect_valid) pc <= redirect_pc;
               if (io_imem_req_ready) begin
                  state <= S_WAIT;
                  kill  <= io_redirect_valid;
               end else if (io_halt && !io_redirect_valid) begin
                  state <= S_HALT;
               end
            end
            S_WAIT: begin
               if (io_redirect_valid) begin
                  pc   <= redirect_pc;
                  kill <= ~io_imem_resp_valid;
                  if (io_imem_resp_valid) state <= S_REQ;
               end else if (io_imem_resp_valid) begin
                  kill  <= 1'b0;
                  state <= kill ? S_REQ : S_HOLD;
                  if (!kill) begin
                     inst_q <= io_imem_resp_data;
                     pc_q   <= pc;
                     pc     <= pc + XLEN'(4);
                  end
               end
            end
            S_HOLD: begin
               if (io_redirect_valid) begin
                  pc    <= redirect_pc;
                  state <= S_REQ;
               end else if (io_out_ready) begin
                  state <= io_halt ? S_HALT : S_REQ;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_ifu.sv
// tb_ifu: randomized and directed fetch traffic checked against a flag-level reference model
module tb_ifu;
   import ifu_pkg::*;
   logic        clock = 1'b0;
   logic        reset;
   logic        io_imem_req_valid, io_imem_req_ready;
   logic [63:0] io_imem_req_addr;
   logic        io_imem_resp_valid;
   logic [31:0] io_imem_resp_data;
   logic        io_redirect_valid;
   logic [63:0] io_redirect_pc;
   logic        io_halt;
   logic        io_out_valid, io_out_ready;
   logic [31:0] io_out_inst;
   logic [63:0] io_out_pc;

   ifu dut (
      .clock(clock), .reset(reset),
      .io_imem_req_valid(io_imem_req_valid), .io_imem_req_ready(io_imem_req_ready),
      .io_imem_req_addr(io_imem_req_addr), .io_imem_resp_valid(io_imem_resp_valid),
      .io_imem_resp_data(io_imem_resp_data), .io_redirect_valid(io_redirect_valid),
      .io_redirect_pc(io_redirect_pc), .io_halt(io_halt), .io_out_valid(io_out_valid),
      .io_out_ready(io_out_ready), .io_out_inst(io_out_inst), .io_out_pc(io_out_pc)
   );

   always #5 clock = ~clock;

   int checks = 0, failures = 0, cyc = 0;
   // reference model: next fetch address plus what is in flight / held
   logic [63:0] m_pc, m_out_pc;
   bit m_busy, m_stale, m_have, m_halted;
   // instruction memory model
   bit mem_pend, ovr_en, spur, mem_clr;
   int mem_cnt, mem_delay;
   logic [31:0] mem_data, ovr;
   logic [63:0] req_q[$], out_q[$];
   logic [31:0] outi_q[$];
   int req_t[$], out_t[$];

   function automatic logic [31:0] f(input logic [63:0] a);
      return 32'h13 ^ ((a[31:0] - 32'h8000_0000) << 8) ^ a[63:32];
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic clr();
      req_q.delete(); req_t.delete(); out_q.delete(); outi_q.delete(); out_t.delete();
   endtask

   task automatic step(input bit rst_i, input bit rdy, input bit ordy, input bit redir,
                       input logic [63:0] rpc, input bit halt_i);
      bit exp_req, exp_out, resp;
      logic [63:0] tgt;
      @(negedge clock);
      reset = rst_i; io_imem_req_ready = rdy; io_out_ready = ordy;
      io_redirect_valid = redir; io_redirect_pc = rpc; io_halt = halt_i;
      if (rst_i && mem_clr) mem_pend = 0;
      io_imem_resp_valid = 1'b0;
      io_imem_resp_data = $urandom;
      if (mem_pend) begin
         if (mem_cnt == 0) begin
            io_imem_resp_valid = 1'b1; io_imem_resp_data = mem_data; mem_pend = 0;
         end else mem_cnt--;
      end else if (spur && $urandom_range(7) == 0) io_imem_resp_valid = 1'b1;
      #1;
      exp_req = !rst_i && !m_busy && !m_have && !m_halted;
      exp_out = !rst_i && m_have && !redir;
      chk("req_valid", 64'(io_imem_req_valid), 64'(exp_req));
      if (exp_req) chk("req_addr", io_imem_req_addr, m_pc);
      chk("out_valid", 64'(io_out_valid), 64'(exp_out));
      if (exp_out) begin
         chk("out_pc", io_out_pc, m_out_pc);
         chk("out_inst", 64'(io_out_inst), 64'(f(m_out_pc)));
      end
      if (io_imem_req_valid && rdy) begin
         req_q.push_back(io_imem_req_addr); req_t.push_back(cyc);
         mem_pend = 1;
         mem_cnt = (mem_delay == 0) ? int'($urandom_range(2)) : mem_delay - 1;
         mem_data = ovr_en ? ovr : f(io_imem_req_addr);
         ovr_en = 0;
      end
      if (io_out_valid && ordy) begin
         out_q.push_back(io_out_pc); outi_q.push_back(io_out_inst); out_t.push_back(cyc);
      end
      resp = io_imem_resp_valid;
      tgt = {rpc[63:2], 2'b00};
      if (rst_i) begin
         m_pc = RESET_PC; m_busy = 0; m_stale = 0; m_have = 0; m_halted = 0;
      end else if (m_halted) begin
      end else if (redir) begin
         m_pc = tgt;
         if (m_have) m_have = 0;
         else if (m_busy) begin
            if (resp) begin m_busy = 0; m_stale = 0; end
            else m_stale = 1;
         end else if (rdy) begin m_busy = 1; m_stale = 1; end
      end else if (m_have) begin
         if (ordy) begin m_have = 0; m_halted = halt_i; end
      end else if (m_busy) begin
         if (resp) begin
            m_busy = 0;
            if (m_stale) m_stale = 0;
            else begin m_have = 1; m_out_pc = m_pc; m_pc = m_pc + 64'd4; end
         end
      end else if (rdy) m_busy = 1;
      else if (halt_i) m_halted = 1;
      cyc++;
   endtask

   initial begin
      logic [63:0] rpc;
      mem_pend = 0; ovr_en = 0; spur = 0; mem_clr = 1; mem_delay = 1;
      step(1, 1, 1, 0, 0, 0); step(1, 1, 1, 0, 0, 0);
      // straight-line fetch, ready memory with one-cycle response
      clr();
      repeat (9) step(0, 1, 1, 0, 0, 0);
      chk("sl_req0", req_q[0], 64'h8000_0000);
      chk("sl_req1", req_q[1], 64'h8000_0004);
      chk("sl_req2", req_q[2], 64'h8000_0008);
      chk("sl_out_pc0", out_q[0], 64'h8000_0000);
      chk("sl_out_inst0", 64'(outi_q[0]), 64'h13);
      chk("sl_out_pc1", out_q[1], 64'h8000_0004);
      chk("sl_out_spacing", 64'(out_t[1] - out_t[0]), 64'd3);
      chk("sl_req_spacing", 64'(req_t[1] - req_t[0]), 64'd3);
      // decode backpressure
      clr();
      step(0, 1, 1, 0, 0, 0); step(0, 0, 1, 0, 0, 0);
      repeat (5) step(0, 1, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0);
      chk("bp_out_count", 64'(out_q.size()), 64'd1);
      chk("bp_req_count", 64'(req_q.size()), 64'd1);
      chk("bp_out_pc", out_q[0], 64'h8000_000C);
      // redirect while waiting; the pending word must be dropped
      clr();
      mem_delay = 2; ovr_en = 1; ovr = 32'hdeadbeef;
      step(0, 1, 1, 0, 0, 0);
      step(0, 0, 1, 1, 64'h8000_0103, 0);
      step(0, 0, 1, 0, 0, 0);
      mem_delay = 1;
      step(0, 1, 1, 0, 0, 0); step(0, 0, 1, 0, 0, 0); step(0, 0, 1, 0, 0, 0);
      chk("rw_req_addr", req_q[1], 64'h8000_0100);
      chk("rw_out_count", 64'(out_q.size()), 64'd1);
      chk("rw_out_pc", out_q[0], 64'h8000_0100);
      // redirect coincident with response, then in hold
      clr();
      step(0, 1, 1, 0, 0, 0);
      step(0, 0, 1, 1, 64'h8000_0200, 0);
      step(0, 1, 1, 0, 0, 0);
      chk("rr_req_addr", req_q[1], 64'h8000_0200);
      step(0, 0, 1, 0, 0, 0);
      step(0, 1, 1, 1, 64'h8000_0300, 0);
      step(0, 1, 1, 0, 0, 0);
      chk("rh_req_addr", req_q[2], 64'h8000_0300);
      chk("rr_out_count", 64'(out_q.size()), 64'd0);
      step(0, 0, 1, 0, 0, 0); step(0, 0, 1, 0, 0, 0);
      // halt raised while waiting
      clr();
      step(0, 1, 1, 0, 0, 0);
      step(0, 0, 1, 0, 0, 1);
      step(0, 1, 1, 0, 0, 1);
      for (int i = 0; i < 20; i++) step(0, 1, 1, (i % 5) == 0, 64'h8000_0400, 0);
      chk("halt_out_count", 64'(out_q.size()), 64'd1);
      chk("halt_out_pc", out_q[0], 64'h8000_0304);
      chk("halt_req_count", 64'(req_q.size()), 64'd1);
      step(1, 1, 1, 0, 0, 0); step(1, 1, 1, 0, 0, 0);
      // wraparound of the PC
      clr();
      step(0, 0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFE, 0);
      step(0, 1, 1, 0, 0, 0); step(0, 0, 1, 0, 0, 0); step(0, 0, 1, 0, 0, 0);
      mem_delay = 3; ovr_en = 1; ovr = 32'hbad0_0bad; mem_clr = 0;
      step(0, 1, 1, 0, 0, 0);
      chk("wrap_req0", req_q[0], 64'hFFFF_FFFF_FFFF_FFFC);
      chk("wrap_req1", req_q[1], 64'h0);
      chk("wrap_out_pc", out_q[0], 64'hFFFF_FFFF_FFFF_FFFC);
      // reset while waiting; the late response must be ignored
      clr();
      step(1, 0, 1, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0); step(0, 0, 1, 0, 0, 0);
      mem_delay = 1;
      step(0, 1, 1, 0, 0, 0); step(0, 0, 1, 0, 0, 0); step(0, 0, 1, 0, 0, 0);
      chk("rst_req_addr", req_q[0], 64'h8000_0000);
      chk("rst_out_count", 64'(out_q.size()), 64'd1);
      chk("rst_out_pc", out_q[0], 64'h8000_0000);
      chk("rst_out_inst", 64'(outi_q[0]), 64'h13);
      // randomized traffic
      mem_clr = 1; spur = 1; mem_delay = 0;
      for (int i = 0; i < 3000; i++) begin
         rpc = ($urandom_range(7) == 0) ? {$urandom(), $urandom()}
                                        : 64'h8000_0000 + 64'($urandom_range(0, 4095));
         step((m_halted && $urandom_range(15) == 0) || $urandom_range(499) == 0,
              $urandom_range(3) != 0, $urandom_range(2) != 0, $urandom_range(11) == 0,
              rpc, $urandom_range(149) == 0);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
